mw_load_stage: RTL and testbench

//  M->W pipeline register plus W-stage load extender. Captures the raw word that the data memory reads

---
 rtl/mw_load_stage_pkg.sv | 36 +++
 rtl/mw_load_stage_extender.sv | 58 +++++
 rtl/mw_load_stage.sv | 86 ++++++++
 tb/tb_mw_load_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_load_stage_pkg.sv
// Shared instruction-ID encodings plus the small set of types used by the
// M->W load stage and its load extender.

`ifndef MW_INSTR_DEFS_SV
`define MW_INSTR_DEFS_SV
`define ID_NOP  11'd0
`define ID_LW   11'd1
`define ID_LB   11'd2
`define ID_LBU  11'd3
`define ID_LH   11'd4
`define ID_LHU  11'd5
`define ID_ADDU 11'd6
`define ID_SW   11'd7
`endif

package mw_load_stage_pkg;

  // Only the low two address bits survive into W; they pick the byte/half lane.
  localparam int OFF_W = 2;
  typedef logic [OFF_W-1:0] off_t;

  // How the raw memory word is turned into a register value.
  typedef enum logic [1:0] {
    EXT_NONE,
    EXT_WORD,
    EXT_BYTE,
    EXT_HALF
  } ext_kind_e;

  // True for every instruction whose write-back value comes from memory.
  function automatic logic is_load_id(input logic [31:0] id);
    return (id == 32'(`ID_LW))  || (id == 32'(`ID_LB)) || (id == 32'(`ID_LBU)) ||
           (id == 32'(`ID_LH))  || (id == 32'(`ID_LHU));
  endfunction

endpackage

// File: rtl/mw_load_stage_extender.sv
// Combinational load extender: selects the addressed byte/half of a word,
// sign- or zero-extends it, and flags misaligned word/half loads.

module load_extender
  import mw_load_stage_pkg::*;
#(
  parameter int ID_W = 11
) (
  input  logic [31:0]     word,
  input  off_t            off,
  input  logic [ID_W-1:0] id,
  output logic [31:0]     data,
  output logic            misalign
);

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  ext_kind_e         kind;
  logic              sign_ext;
  logic [BYTE_W-1:0] sel_byte;
  logic [HALF_W-1:0] sel_half;

  // Decode the instruction into an extension kind and signedness.
  always_comb begin
    kind     = EXT_NONE;
    sign_ext = 1'b0;
    case (id)
      ID_W'(`ID_LW):  kind = EXT_WORD;
      ID_W'(`ID_LB):  begin kind = EXT_BYTE; sign_ext = 1'b1; end
      ID_W'(`ID_LBU): kind = EXT_BYTE;
      ID_W'(`ID_LH):  begin kind = EXT_HALF; sign_ext = 1'b1; end
      ID_W'(`ID_LHU): kind = EXT_HALF;
      default:        kind = EXT_NONE;
    endcase
  end

  // Pick the addressed lane, extend it, and check natural alignment.
  always_comb begin
    sel_byte = word[{off, 3'b000} +: BYTE_W];
    sel_half = word[{off[1], 4'b0000} +: HALF_W];
    data     = 32'h0;
    misalign = 1'b0;
    case (kind)
      EXT_WORD: begin
        data     = word;
        misalign = (off != 2'b00);
      end
      EXT_BYTE: data = {{(32-BYTE_W){sign_ext & sel_byte[BYTE_W-1]}}, sel_byte};
      EXT_HALF: begin
        data     = {{(32-HALF_W){sign_ext & sel_half[HALF_W-1]}}, sel_half};
        misalign = off[0];
      end
      default:  data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mw_load_stage.sv
// M->W pipeline register with the W-stage load extender. Registers the raw
// memory word and M-stage bookkeeping, then builds the write-back value.

module mw_load_stage
  import mw_load_stage_pkg::*;
#(
  parameter int          ID_W     = 11,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            intReq,
  input  logic            hold,
  input  logic            M_valid,
  input  logic [31:0]     M_PC,
  input  logic [ID_W-1:0] M_instructionID,
  input  logic [31:0]     M_addr,
  input  logic [31:0]     M_memWord,
  input  logic [31:0]     M_aluResult,
  input  logic [4:0]      M_regWriteAddr,
  output logic            W_valid,
  output logic [31:0]     W_PC,
  output logic [ID_W-1:0] W_instructionID,
  output logic            W_regWriteEn,
  output logic [4:0]      W_regWriteAddr,
  output logic [31:0]     W_regWriteData,
  output logic            W_loadMisalign
);

  logic [31:0] w_word;
  off_t        w_off;
  logic [31:0] w_alu;
  logic [31:0] ext_data;
  logic        ext_misalign;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^M_addr[31:OFF_W];

  // Pipeline register: hold freezes everything, intReq injects a bubble,
  // otherwise capture M (an invalid M instruction becomes a bubble).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      W_valid         <= 1'b0;
      W_PC            <= RESET_PC;
      W_instructionID <= '0;
      W_regWriteAddr  <= 5'd0;
      w_word          <= 32'h0;
      w_off           <= '0;
      w_alu           <= 32'h0;
    end else if (hold) begin
      W_valid <= W_valid;
    end else if (intReq || !M_valid) begin
      W_valid         <= 1'b0;
      W_PC            <= RESET_PC;
      W_instructionID <= '0;
      W_regWriteAddr  <= 5'd0;
    end else begin
      W_valid         <= 1'b1;
      W_PC            <= M_PC;
      W_instructionID <= M_instructionID;
      W_regWriteAddr  <= M_regWriteAddr;
      w_word          <= M_memWord;
      w_off           <= M_addr[OFF_W-1:0];
      w_alu           <= M_aluResult;
    end
  end

  load_extender #(.ID_W(ID_W)) u_ext (
    .word     (w_word),
    .off      (w_off),
    .id       (W_instructionID),
    .data     (ext_data),
    .misalign (ext_misalign)
  );

  // Write-back value is zeroed whenever nothing is written so forwarding sees a clean 0.
  always_comb begin
    W_regWriteEn   = W_valid && (W_regWriteAddr != 5'd0);
    W_regWriteData = 32'h0;
    if (W_regWriteEn) begin
      W_regWriteData = is_load_id(32'(W_instructionID)) ? ext_data : w_alu;
    end
    W_loadMisalign = ext_misalign;
  end

endmodule

// File: tb/tb_mw_load_stage.sv
// Self-checking bench for mw_load_stage: directed scenarios plus a randomized
// run compared against a behavioural model of the W register.

module tb_mw_load_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        intReq = 1'b0;
  logic        hold = 1'b0;
  logic        M_valid = 1'b0;
  logic [31:0] M_PC = 32'h0;
  logic [10:0] M_instructionID = 11'd0;
  logic [31:0] M_addr = 32'h0;
  logic [31:0] M_memWord = 32'h0;
  logic [31:0] M_aluResult = 32'h0;
  logic [4:0]  M_regWriteAddr = 5'd0;
  logic        W_valid;
  logic [31:0] W_PC;
  logic [10:0] W_instructionID;
  logic        W_regWriteEn;
  logic [4:0]  W_regWriteAddr;
  logic [31:0] W_regWriteData;
  logic        W_loadMisalign;

  int checks = 0;
  int errors = 0;

  mw_load_stage #(.ID_W(11), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .intReq          (intReq),
    .hold            (hold),
    .M_valid         (M_valid),
    .M_PC            (M_PC),
    .M_instructionID (M_instructionID),
    .M_addr          (M_addr),
    .M_memWord       (M_memWord),
    .M_aluResult     (M_aluResult),
    .M_regWriteAddr  (M_regWriteAddr),
    .W_valid         (W_valid),
    .W_PC            (W_PC),
    .W_instructionID (W_instructionID),
    .W_regWriteEn    (W_regWriteEn),
    .W_regWriteAddr  (W_regWriteAddr),
    .W_regWriteData  (W_regWriteData),
    .W_loadMisalign  (W_loadMisalign)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [10:0] id,
                       input logic [31:0] addr, input logic [31:0] word,
                       input logic [31:0] alu, input logic [4:0] rd);
    M_valid = v; M_PC = pc; M_instructionID = id; M_addr = addr;
    M_memWord = word; M_aluResult = alu; M_regWriteAddr = rd;
    hold = 1'b0; intReq = 1'b0;
  endtask

  // Reference write-back value computed straight from the load rules.
  function automatic logic [31:0] ref_data(input logic v, input logic [10:0] id,
                                           input logic [31:0] word, input int off,
                                           input logic [31:0] alu, input logic [4:0] rd);
    int unsigned lane;
    int s;
    if (!v || rd == 0) return 32'h0;
    if (id == `ID_LW) return word;
    if (id == `ID_LB || id == `ID_LBU) begin
      lane = (word >> (8 * off)) & 32'hFF;
      s = int'(lane);
      if (id == `ID_LB && s > 127) s = s - 256;
      return 32'(s);
    end
    if (id == `ID_LH || id == `ID_LHU) begin
      lane = (word >> (16 * (off / 2))) & 32'hFFFF;
      s = int'(lane);
      if (id == `ID_LH && s > 32767) s = s - 65536;
      return 32'(s);
    end
    return alu;
  endfunction

  function automatic logic ref_misalign(input logic [10:0] id, input int off);
    if (id == `ID_LW) return (off % 4) != 0;
    if (id == `ID_LH || id == `ID_LHU) return (off % 2) != 0;
    return 1'b0;
  endfunction

  task automatic test_reset();
    step(); step();
    checks++;
    if (W_valid !== 1'b0 || W_PC !== RST_PC || W_regWriteEn !== 1'b0 ||
        W_regWriteData !== 32'h0 || W_loadMisalign !== 1'b0 || W_instructionID !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b pc=%h en=%b data=%h mis=%b id=%0d, want 0 %h 0 0 0 0",
               W_valid, W_PC, W_regWriteEn, W_regWriteData, W_loadMisalign, W_instructionID, RST_PC);
    end
    reset = 1'b1;
    drive(1'b1, 32'h0040_0010, `ID_ADDU, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd9);
    step();
    checks++;
    if (W_valid !== 1'b1 || W_regWriteData !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL pre_async_reset: valid=%b data=%h, want 1 cafef00d", W_valid, W_regWriteData);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (W_valid !== 1'b0 || W_regWriteEn !== 1'b0 || W_regWriteData !== 32'h0 || W_PC !== RST_PC) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b en=%b data=%h pc=%h, want 0 0 0 %h",
               W_valid, W_regWriteEn, W_regWriteData, W_PC, RST_PC);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, `ID_NOP, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
  endtask

  task automatic test_lb();
    logic [31:0] want [4] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    for (int off = 0; off < 4; off++) begin
      drive(1'b1, 32'h0040_0100 + 32'(off * 4), `ID_LB, 32'h0000_2000 + 32'(off),
            32'h80FF_7F01, 32'h1111_1111, 5'd3);
      step();
      checks++;
      if (W_regWriteData !== want[off]) begin
        errors++;
        $display("[TB] FAIL lb_off%0d: got %h want %h", off, W_regWriteData, want[off]);
      end
    end
  endtask

  task automatic test_half();
    logic [10:0] ids  [3] = '{`ID_LHU, `ID_LH, `ID_LH};
    logic [31:0] offs [3] = '{32'd2, 32'd2, 32'd0};
    logic [31:0] want [3] = '{32'h0000_8001, 32'hFFFF_8001, 32'h0000_7FFE};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0040_0200, ids[i], 32'h0000_3000 + offs[i], 32'h8001_7FFE, 32'h0, 5'd4);
      step();
      checks++;
      if (W_regWriteData !== want[i] || W_loadMisalign !== 1'b0) begin
        errors++;
        $display("[TB] FAIL half_case%0d: data=%h mis=%b want %h 0", i, W_regWriteData, W_loadMisalign, want[i]);
      end
    end
  endtask

  task automatic test_regwrite();
    drive(1'b1, 32'h0040_0300, `ID_LW, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 5'd0);
    step();
    checks++;
    if (W_regWriteEn !== 1'b0 || W_regWriteData !== 32'h0 || W_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lw_to_r0: en=%b data=%h valid=%b want 0 0 1", W_regWriteEn, W_regWriteData, W_valid);
    end
    drive(1'b1, 32'h0040_0304, `ID_ADDU, 32'h0000_0041, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5);
    step();
    checks++;
    if (W_regWriteEn !== 1'b1 || W_regWriteData !== 32'h1234_5678 || W_regWriteAddr !== 5'd5 ||
        W_PC !== 32'h0040_0304) begin
      errors++;
      $display("[TB] FAIL addu_r5: en=%b data=%h rd=%0d pc=%h want 1 12345678 5 00400304",
               W_regWriteEn, W_regWriteData, W_regWriteAddr, W_PC);
    end
  endtask

  task automatic test_intreq_hold();
    drive(1'b1, 32'h0040_0400, `ID_LW, 32'h0000_0100, 32'hA5A5_5A5A, 32'h0, 5'd7);
    intReq = 1'b1;
    step();
    checks++;
    if (W_valid !== 1'b0 || W_PC !== RST_PC || W_regWriteEn !== 1'b0 || W_instructionID !== 11'd0) begin
      errors++;
      $display("[TB] FAIL intreq_bubble: valid=%b pc=%h en=%b id=%0d want 0 %h 0 0",
               W_valid, W_PC, W_regWriteEn, W_instructionID, RST_PC);
    end
    drive(1'b1, 32'h0040_0404, `ID_LW, 32'h0000_0104, 32'h0BAD_F00D, 32'h0, 5'd8);
    step();
    drive(1'b1, 32'h0040_0408, `ID_LB, 32'h0000_0109, 32'hFFFF_FFFF, 32'h0, 5'd9);
    hold = 1'b1; intReq = 1'b1;
    step();
    checks++;
    if (W_valid !== 1'b1 || W_PC !== 32'h0040_0404 || W_regWriteData !== 32'h0BAD_F00D ||
        W_regWriteAddr !== 5'd8) begin
      errors++;
      $display("[TB] FAIL hold_beats_intreq: valid=%b pc=%h data=%h rd=%0d want 1 00400404 0badf00d 8",
               W_valid, W_PC, W_regWriteData, W_regWriteAddr);
    end
    hold = 1'b0;
    step();
    checks++;
    if (W_valid !== 1'b0 || W_PC !== RST_PC || W_regWriteData !== 32'h0) begin
      errors++;
      $display("[TB] FAIL intreq_after_hold: valid=%b pc=%h data=%h want 0 %h 0",
               W_valid, W_PC, W_regWriteData, RST_PC);
    end
    intReq = 1'b0;
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h0040_0500, `ID_LW, 32'h0000_1002, 32'h1234_5678, 32'h0, 5'd2);
    step();
    checks++;
    if (W_loadMisalign !== 1'b1 || W_regWriteData !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL lw_misalign: mis=%b data=%h want 1 12345678", W_loadMisalign, W_regWriteData);
    end
    drive(1'b1, 32'h0040_0504, `ID_LH, 32'h0000_1001, 32'h1234_5678, 32'h0, 5'd2);
    step();
    checks++;
    if (W_loadMisalign !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lh_misalign: mis=%b want 1", W_loadMisalign);
    end
    for (int off = 0; off < 4; off++) begin
      drive(1'b1, 32'h0040_0508, `ID_LB, 32'h0000_1000 + 32'(off), 32'h1234_5678, 32'h0, 5'd2);
      step();
      checks++;
      if (W_loadMisalign !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lb_aligned_off%0d: mis=%b want 0", off, W_loadMisalign);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] pool [8] = '{`ID_NOP, `ID_LW, `ID_LB, `ID_LBU, `ID_LH, `ID_LHU, `ID_ADDU, `ID_SW};
    logic        e_valid;
    logic [31:0] e_pc, e_word, e_alu, w_data;
    logic [10:0] e_id;
    logic [4:0]  e_rd;
    int          e_off;
    logic        w_en;
    e_valid = 1'b0; e_pc = RST_PC; e_id = 11'd0; e_rd = 5'd0;
    e_word = 32'h0; e_alu = 32'h0; e_off = 0;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom, pool[$urandom_range(0, 7)], $urandom,
            $urandom, $urandom, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      if (i > 0) begin
        hold   = ($urandom_range(0, 4) == 0);
        intReq = ($urandom_range(0, 6) == 0);
      end
      if (hold) begin
        // W keeps everything
      end else if (intReq || !M_valid) begin
        e_valid = 1'b0; e_pc = RST_PC; e_id = 11'd0; e_rd = 5'd0;
      end else begin
        e_valid = 1'b1; e_pc = M_PC; e_id = M_instructionID; e_rd = M_regWriteAddr;
        e_word = M_memWord; e_alu = M_aluResult; e_off = int'(M_addr % 4);
      end
      step();
      w_en   = e_valid && (e_rd != 0);
      w_data = ref_data(e_valid, e_id, e_word, e_off, e_alu, e_rd);
      checks++;
      if (W_valid !== e_valid || W_PC !== e_pc || W_instructionID !== e_id ||
          W_regWriteAddr !== e_rd || W_regWriteEn !== w_en || W_regWriteData !== w_data ||
          W_loadMisalign !== ref_misalign(e_id, e_off)) begin
        errors++;
        $display("[TB] FAIL random_%0d: got v=%b pc=%h id=%0d rd=%0d en=%b d=%h mis=%b want v=%b pc=%h id=%0d rd=%0d en=%b d=%h mis=%b",
                 i, W_valid, W_PC, W_instructionID, W_regWriteAddr, W_regWriteEn, W_regWriteData,
                 W_loadMisalign, e_valid, e_pc, e_id, e_rd, w_en, w_data, ref_misalign(e_id, e_off));
      end
    end
    hold = 1'b0; intReq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lb();
    test_half();
    test_regwrite();
    test_intreq_hold();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
